entropy_seed_gen: RTL
=====================

// Module: entropy_seed_gen
// PURPOSE
//  Parametrised successor seed generator for the PRNG core. Conditions a raw entropy stream
//  (NLFSR taps or ADC words) through an xorshift ADC model and a shifting XOR pool.
//  On request it emits NUM_SEEDS whitened seeds with a valid/ready handshake.
//  Sits between the NLFSR/entropy source and the PRNG/SHA-256 seed inputs.
// PARAMETERS
//  SRC_W       16  width of src_in entropy word (1..POOL_W)
//  POOL_W      64  pool and seed width; multiple of SRC_W
//  NUM_SEEDS   2   seeds produced per request (1..8)
//  REP_LIMIT   4   identical consecutive samples that trip the health test (>=2)
//  localparam SPS = POOL_W/SRC_W samples per seed; CNT_W = $clog2(SPS*NUM_SEEDS)
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 synchronous, active-high reset
//  src_in      in   SRC_W             raw entropy word
//  src_valid   in   1                 src_in valid; sample accepted when high in COLLECT
//  req         in   1                 start request; sampled only in IDLE
//  seed_out    out  NUM_SEEDS*POOL_W  seed k at [k*POOL_W +: POOL_W]
//  seed_valid  out  1                 seed_out valid; held until seed_ready
//  seed_ready  in   1                 consumer accepts seeds
//  busy        out  1                 high in COLLECT and VALID
//  health_fail out  1                 repetition failure flag (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst). Every register updates on posedge clk.
//  - Reset: state=IDLE, seed_out=0, seed_valid=0, busy=0, health_fail=0, pool=0, cnt=0.
//    Also adc_q=ADC_INIT (64'hA3F7C9D5826B4E1D, replicated/truncated to POOL_W).
//  - ADC model on each accepted sample: a = adc_q ^ zext(src_in); adc_n = a ^ (a>>1) ^ (a<<3).
//    Shifts are logical at POOL_W bits; carries out are dropped. Next adc_q = adc_n.
//  - Pool on each accepted sample: pool_n = (pool << SRC_W) ^ adc_n.
//  - FSM IDLE: req=1 -> COLLECT; cnt=0; health_fail cleared. req is ignored in all other states.
//  - FSM COLLECT: src_valid=0 stalls with no state change. src_valid=1 accepts one sample and cnt++.
//    When cnt%SPS==SPS-1, slot k=cnt/SPS loads seed_out[k].
//    Even k loads pool_n^WHITEN_A; odd k loads ~pool_n^WHITEN_B.
//    The pool is not cleared between slots.
//    The last sample (cnt==SPS*NUM_SEEDS-1) moves the FSM to VALID; cnt wraps to 0.
//  - FSM VALID: seed_valid=1 and seed_out stable. seed_valid&seed_ready -> IDLE, with seed_valid=0 the next cycle.
//    seed_out keeps its last value after the handshake.
//  - Latency (defaults): req at cycle 0, src_valid held high -> samples accepted cycles 1..8 -> seed_valid high at cycle 9.
//  - A req coinciding with the handshake cycle is ignored, because the FSM is not yet in IDLE.
//  - rst asserted mid-COLLECT or mid-VALID aborts the round; all reset values apply the next cycle.
// CONFIGURATION
//  Macro ENTROPY_SEED_HEALTH_EN:
//  - Defined: repetition-count test in COLLECT. If REP_LIMIT consecutive accepted src_in values are equal,
//    health_fail is set (sticky until the next accepted req). FSM -> IDLE, seed_valid never asserts,
//    seed_out is left unchanged, adc_q and pool are retained.
//  - Undefined: no checker logic; health_fail is tied to 0.
// STRUCTURE
//  - Package prng_seed_pkg holds ADC_INIT, WHITEN_A=64'h7729CEBAF02D3D20 and WHITEN_B=64'hE7B4D2A9853C6F19
//    (replicated/truncated to POOL_W) and typedef enum seed_state_t {IDLE, COLLECT, VALID}.
//  - One sub-module, seed_adc_model: holds adc_q and the xorshift; ports clk, rst, en, src_in, adc_n.
//  - Top level holds the FSM, counter, pool, seed registers and the optional health checker.
// TESTING
//  1. Reset, then req=1 at cycle 0 with src_in=16'h0000 and src_valid held high
//     -> seed_valid=1 at cycle 9; seed_out matches the golden model; busy=1 during cycles 1..9.
//  2. Same stimulus with src_valid toggling 1/0 -> seed_valid at cycle 17; seed_out identical to test 1.
//  3. Hold seed_ready=0 for 5 cycles in VALID -> seed_valid and seed_out stable;
//     seed_ready=1 -> seed_valid=0 the next cycle; a req pulsed during VALID is ignored.
//  4. Assert rst after 3 accepted samples -> next cycle state=IDLE, all outputs 0;
//     a new req then reproduces test 1 exactly.
//  5. ENTROPY_SEED_HEALTH_EN defined, src_in=16'hBEEF repeated with REP_LIMIT=4
//     -> health_fail=1 after the 4th sample; FSM IDLE; no seed_valid.
//     Rerun with the macro undefined -> health_fail=0 and seed_valid at cycle 9.
//  6. POOL_W=128, SRC_W=32, NUM_SEEDS=3 -> 12 samples, seed_valid at cycle 13;
//     slots 0 and 2 use WHITEN_A and slot 1 uses WHITEN_B, all matching the golden model.

Source files
------------

// File: rtl/prng_seed_pkg.sv
// Shared constants and state type for the entropy seed generator.
// Constants are 64-bit patterns; rep_const() replicates them so a design
// can truncate to its own pool width (up to MAX_POOL_W bits).
package prng_seed_pkg;

  localparam int          MAX_POOL_W = 1024;
  localparam logic [63:0] ADC_INIT   = 64'hA3F7C9D5826B4E1D;
  localparam logic [63:0] WHITEN_A   = 64'h7729CEBAF02D3D20;
  localparam logic [63:0] WHITEN_B   = 64'hE7B4D2A9853C6F19;

  typedef enum logic [1:0] {IDLE, COLLECT, VALID} seed_state_t;

  function automatic logic [MAX_POOL_W-1:0] rep_const(input logic [63:0] v);
    return {(MAX_POOL_W/64){v}};
  endfunction

endpackage

// File: rtl/seed_adc_model.sv
// Xorshift ADC model: folds each accepted entropy word into a POOL_W-bit
// state. adc_n is the combinational successor, adc_q advances when en is high.
module seed_adc_model
  import prng_seed_pkg::*;
#(
  parameter int SRC_W  = 16,
  parameter int POOL_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SRC_W-1:0]  src_in,
  output logic [POOL_W-1:0] adc_n
);

  localparam logic [MAX_POOL_W-1:0] INIT_FULL = rep_const(ADC_INIT);
  localparam logic [POOL_W-1:0]     INIT_VAL  = INIT_FULL[POOL_W-1:0];

  logic [POOL_W-1:0] adc_q;
  logic [POOL_W-1:0] mix;

  // Successor state: mix in the raw word, then a logical xorshift (carries dropped).
  always_comb begin
    mix   = adc_q ^ POOL_W'(src_in);
    adc_n = mix ^ (mix >> 1) ^ (mix << 3);
  end

  // State register advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst)     adc_q <= INIT_VAL;
    else if (en) adc_q <= adc_n;
  end

endmodule

// File: rtl/entropy_seed_gen.sv
// Entropy seed generator top: collects SPS*NUM_SEEDS raw samples per request,
// conditions them through the ADC model and a shifting XOR pool, and presents
// NUM_SEEDS whitened seeds with a valid/ready handshake.
// Optional repetition-count health test: define ENTROPY_SEED_HEALTH_EN.
module entropy_seed_gen
  import prng_seed_pkg::*;
#(
  parameter int SRC_W     = 16,
  parameter int POOL_W    = 64,
  parameter int NUM_SEEDS = 2,
  parameter int REP_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SRC_W-1:0]            src_in,
  input  logic                        src_valid,
  input  logic                        req,
  output logic [NUM_SEEDS*POOL_W-1:0] seed_out,
  output logic                        seed_valid,
  input  logic                        seed_ready,
  output logic                        busy,
  output logic                        health_fail
);

  localparam int SPS   = POOL_W / SRC_W;
  localparam int TOTAL = SPS * NUM_SEEDS;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [MAX_POOL_W-1:0] WA_FULL = rep_const(WHITEN_A);
  localparam logic [MAX_POOL_W-1:0] WB_FULL = rep_const(WHITEN_B);
  localparam logic [POOL_W-1:0]     WA      = WA_FULL[POOL_W-1:0];
  localparam logic [POOL_W-1:0]     WB      = WB_FULL[POOL_W-1:0];

  seed_state_t                 state, state_n;
  logic [CNT_W-1:0]            cnt;
  logic [POOL_W-1:0]           pool;
  logic [POOL_W-1:0]           pool_n;
  logic [POOL_W-1:0]           adc_n;
  logic [NUM_SEEDS*POOL_W-1:0] seed_q;
  logic                        accept;
  logic                        slot_end;
  logic                        last;
  logic                        trip;
  int                          slot_idx;

  seed_adc_model #(
    .SRC_W (SRC_W),
    .POOL_W(POOL_W)
  ) u_adc (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .src_in(src_in),
    .adc_n (adc_n)
  );

  // Sample acceptance, slot boundaries and the next pool value.
  always_comb begin
    accept   = (state == COLLECT) && src_valid;
    slot_end = ((int'(cnt) % SPS) == (SPS - 1));
    slot_idx = int'(cnt) / SPS;
    last     = (int'(cnt) == (TOTAL - 1));
    pool_n   = (pool << SRC_W) ^ adc_n;
  end

`ifdef ENTROPY_SEED_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [SRC_W-1:0] last_src;
  logic [REP_W-1:0] rep_cnt;
  logic             have_last;
  logic             hf_q;

  // A sample trips the test when it completes a run of REP_LIMIT equal words.
  always_comb begin
    trip = accept && have_last && (src_in == last_src) &&
           (int'(rep_cnt) == (REP_LIMIT - 1));
  end

  // Run-length tracker; the flag is sticky until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src  <= '0;
      rep_cnt   <= '0;
      have_last <= 1'b0;
      hf_q      <= 1'b0;
    end else if ((state == IDLE) && req) begin
      rep_cnt   <= '0;
      have_last <= 1'b0;
      hf_q      <= 1'b0;
    end else if (accept) begin
      last_src  <= src_in;
      have_last <= 1'b1;
      if (have_last && (src_in == last_src)) rep_cnt <= rep_cnt + REP_W'(1);
      else                                   rep_cnt <= REP_W'(1);
      if (trip) hf_q <= 1'b1;
    end
  end

  assign health_fail = hf_q;
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a failed health test abandons the round.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = COLLECT;
      COLLECT: begin
        if (accept && trip)      state_n = IDLE;
        else if (accept && last) state_n = VALID;
      end
      VALID:   if (seed_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    seed_valid = (state == VALID);
    busy       = (state == COLLECT) || (state == VALID);
  end

  // Sample counter, pool and seed slots; the pool carries across slot boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      pool   <= '0;
      seed_q <= '0;
    end else if ((state == IDLE) && req) begin
      cnt <= '0;
    end else if (accept) begin
      pool <= pool_n;
      cnt  <= (last || trip) ? '0 : cnt + CNT_W'(1);
      for (int k = 0; k < NUM_SEEDS; k++) begin
        if (slot_end && !trip && (slot_idx == k)) begin
          if ((k % 2) == 0) seed_q[k*POOL_W +: POOL_W] <= pool_n ^ WA;
          else              seed_q[k*POOL_W +: POOL_W] <= (~pool_n) ^ WB;
        end
      end
    end
  end

  assign seed_out = seed_q;

endmodule
